// File: rtl/mod_updown_chain_pkg.sv
// Shared constants and elaboration helpers for the mod_updown_chain counter.
// Optional saturating behaviour is selected with the CNT_SAT_EN macro.
package mod_updown_chain_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // A digit needs at least two states and W bits wide enough to hold RADIX-1.
    function automatic bit params_legal(input int radix, input int w);
        return (radix >= 2) && (w >= 1) && (w >= clog2(radix));
    endfunction

endpackage

// File: rtl/mod_updown_chain_digit.sv
// One W-bit modulo-RADIX up/down digit with clamped parallel load.
module mod_digit
    import mod_updown_chain_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int W     = 4
) (
    input  logic         CLK,
    input  logic         MR,
    input  logic         step,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         at_term
);

    localparam logic [W:0]   RADIX_X = (W+1)'(RADIX);
    localparam logic [W-1:0] MAX_V   = W'(RADIX - 1);
    localparam logic [W-1:0] ZERO_V  = W'(0);

    logic [W-1:0] q_r;
    logic [W-1:0] d_clamp_s;
    logic [W-1:0] q_next_s;

    // Clamp out-of-range load digits to the largest legal value.
    always_comb begin
        d_clamp_s = d;
        if ({1'b0, d} >= RADIX_X) begin
            d_clamp_s = MAX_V;
        end else begin
            d_clamp_s = d;
        end
    end

    // Next digit value: load beats step, step wraps within 0..RADIX-1.
    always_comb begin
        q_next_s = q_r;
        if (ld) begin
            q_next_s = d_clamp_s;
        end else if (step) begin
            if (up == DIR_UP) begin
                q_next_s = (q_r == MAX_V) ? ZERO_V : (q_r + W'(1));
            end else begin
                q_next_s = (q_r == ZERO_V) ? MAX_V : (q_r - W'(1));
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Digit register with asynchronous master reset.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            q_r <= ZERO_V;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q       = q_r;
    assign at_term = (up == DIR_DN) ? (q_r == ZERO_V) : (q_r == MAX_V);

endmodule

// File: rtl/mod_updown_chain.sv
// Cascadable NDIG-digit modulo-RADIX up/down counter with load, carry and terminal count.
// Define CNT_SAT_EN to make the chain saturate at its end values instead of wrapping.
module mod_updown_chain
    import mod_updown_chain_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int W     = 4,
    parameter int NDIG  = 2
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              EN,
    input  logic              UP,
    input  logic              LD,
    input  logic [NDIG*W-1:0] D,
    output logic [NDIG*W-1:0] Q,
    output logic              CO,
    output logic              TC
);

    if (!params_legal(RADIX, W)) begin : g_param_err
        $error("mod_updown_chain: illegal parameters, need RADIX>=2 and 2**W>=RADIX");
    end

    logic [NDIG-1:0] step_s;
    logic [NDIG-1:0] at_term_s;
    logic            all_term_s;
    logic            base_step_s;
    logic            co_r;

    assign all_term_s = &at_term_s;

`ifdef CNT_SAT_EN
    // Saturation blocks the whole chain once every digit sits at its end value.
    assign base_step_s = EN & ~LD & ~all_term_s;
`else
    assign base_step_s = EN & ~LD;
`endif

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        if (k == 0) begin : g_lsd
            assign step_s[k] = base_step_s;
        end else begin : g_upper
            assign step_s[k] = step_s[k-1] & at_term_s[k-1];
        end

        mod_digit #(
            .RADIX (RADIX),
            .W     (W)
        ) u_digit (
            .CLK     (CLK),
            .MR      (MR),
            .step    (step_s[k]),
            .up      (UP),
            .ld      (LD),
            .d       (D[k*W +: W]),
            .q       (Q[k*W +: W]),
            .at_term (at_term_s[k])
        );
    end

    // Carry marks a full-chain wrap (or a blocked step when saturating).
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            co_r <= 1'b0;
        end else if (LD) begin
            co_r <= 1'b0;
        end else if (EN) begin
            co_r <= all_term_s;
        end else begin
            co_r <= co_r;
        end
    end

    assign CO = co_r;
    assign TC = EN & ~LD & all_term_s;

endmodule

// File: tb/tb_mod_updown_chain.sv
// Self-checking bench for mod_updown_chain: directed test-plan steps then randomized traffic.
module tb_mod_updown_chain;

    localparam int RADIX = 10;
    localparam int W     = 4;
    localparam int NDIG  = 2;
    localparam int MODV  = RADIX ** NDIG;

    logic              CLK = 1'b0;
    logic              MR  = 1'b0;
    logic              EN  = 1'b0;
    logic              UP  = 1'b1;
    logic              LD  = 1'b0;
    logic [NDIG*W-1:0] D   = '0;
    logic [NDIG*W-1:0] Q;
    logic              CO;
    logic              TC;

    int checks   = 0;
    int failures = 0;

    int m_val = 0;
    bit m_co  = 1'b0;

    mod_updown_chain #(.RADIX(RADIX), .W(W), .NDIG(NDIG)) dut (
        .CLK (CLK),
        .MR  (MR),
        .EN  (EN),
        .UP  (UP),
        .LD  (LD),
        .D   (D),
        .Q   (Q),
        .CO  (CO),
        .TC  (TC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NDIG*W-1:0] to_q(input int val);
        logic [NDIG*W-1:0] r;
        int v;
        r = '0;
        v = val;
        for (int k = 0; k < NDIG; k++) begin
            r[k*W +: W] = W'(v % RADIX);
            v = v / RADIX;
        end
        return r;
    endfunction

    function automatic int load_val(input logic [NDIG*W-1:0] dv);
        int val;
        int mul;
        int dk;
        val = 0;
        mul = 1;
        for (int k = 0; k < NDIG; k++) begin
            dk = int'(dv[k*W +: W]);
            if (dk >= RADIX) dk = RADIX - 1;
            val += dk * mul;
            mul *= RADIX;
        end
        return val;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check TC before the edge, advance the model, check Q/CO after it.
    task automatic cycle(input string tag);
        bit term;
        bit tc_exp;
        #1;
        term   = UP ? (m_val == MODV - 1) : (m_val == 0);
        tc_exp = EN && !LD && term;
        chk({tag, ".tc"}, 32'(TC), 32'(tc_exp));
        @(posedge CLK);
        if (LD) begin
            m_val = load_val(D);
            m_co  = 1'b0;
        end else if (EN) begin
            m_co = term;
`ifdef CNT_SAT_EN
            if (!term) m_val = UP ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
`else
            m_val = UP ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
`endif
        end
        #1;
        chk({tag, ".q"}, 32'(Q), 32'(to_q(m_val)));
        chk({tag, ".co"}, 32'(CO), 32'(m_co));
    endtask

    initial begin
        // Reset state while MR is held low.
        #2;
        chk("rst.q", 32'(Q), 32'h0);
        chk("rst.co", 32'(CO), 32'h0);
        chk("rst.tc", 32'(TC), 32'h0);
        @(negedge CLK);
        MR = 1'b1;

        // Load 37, then abort asynchronously mid-cycle.
        LD = 1'b1; D = 8'h37; EN = 1'b1; UP = 1'b1;
        cycle("ld37");
        LD = 1'b0;
        #2;
        MR = 1'b0;
        #1;
        chk("mr_async.q", 32'(Q), 32'h0);
        chk("mr_async.co", 32'(CO), 32'h0);
        m_val = 0;
        m_co  = 1'b0;
        MR = 1'b1; EN = 1'b1; UP = 1'b1;
        cycle("mr_release");
        chk("mr_release.q01", 32'(Q), 32'h01);

        // Wrap up from 99.
        LD = 1'b1; D = 8'h99;
        cycle("ld99");
        LD = 1'b0;
        cycle("up_wrap");
        cycle("up_after_wrap");

        // Wrap down from 00, borrow across digits at 10.
        LD = 1'b1; D = 8'h00;
        cycle("ld00");
        LD = 1'b0; UP = 1'b0;
        cycle("dn_wrap");
        LD = 1'b1; D = 8'h10;
        cycle("ld10");
        LD = 1'b0;
        cycle("dn_borrow");
        chk("dn_borrow.q09", 32'(Q), 32'h09);

        // Clamped load wins over EN.
        LD = 1'b1; EN = 1'b1; D = 8'hAF;
        cycle("ld_clamp");
        chk("ld_clamp.q99", 32'(Q), 32'h99);

        // Reach a state with CO set, then hold for five cycles while toggling UP.
        LD = 1'b0; UP = 1'b1;
        cycle("set_co");
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            UP = ~UP;
            cycle("hold");
        end

        // Saturation / wrap at the top for three edges, then step down.
        LD = 1'b1; D = 8'h99; EN = 1'b1;
        cycle("ld99b");
        LD = 1'b0; UP = 1'b1;
        for (int i = 0; i < 3; i++) cycle("top_run");
        UP = 1'b0;
        cycle("top_down");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            LD = ($urandom_range(7) == 0);
            EN = ($urandom_range(3) != 0);
            UP = 1'($urandom);
            D  = (NDIG*W)'($urandom);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
